pipe_hazard_unit: RTL and testbench

- Parametrised hazard-detection and forwarding controller for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Keeps its own scoreboard of the destinations held in EX, MEM and WB, so datapath stages need not feed back pipeline-register state.
- Produces, per source operand, registered EX-stage forwarding selects, plus load-use stall, branch flush and saturating event counters.
- Replaces the ad-hoc negedge forwarding block in the core.

---
 rtl/pipe_hazard_unit.sv | 178 +++++++++++++++++
 tb/tb_pipe_hazard_unit.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_unit.sv
//------------------------------------------------------------------------------
// pipe_hazard_unit
//
// Hazard-detection and forwarding controller for the 5-stage pipeline
// (IF, ID, EX, MEM, WB). The unit keeps a private scoreboard of the
// destinations held in EX, MEM and WB. This lets the datapath report only
// what the ID stage holds, without feeding pipeline-register state back.
//
// From the ID instruction and the scoreboard it produces:
//   - load-use stalls (combinational),
//   - taken-branch flushes (combinational),
//   - registered EX-stage forwarding selects, one per source operand,
//   - saturating counters of stall cycles and branch flushes.
//
// Parameters:
//   AW          register-address width
//   NUM_SRC     source operands per instruction
//   ZERO_REG_EN 1: register 0 is never a hazard and is never forwarded
//   CNT_W       width of the stall and flush counters
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   id_valid     ID holds a real instruction
//   id_src       source register numbers, operand k at [k*AW +: AW]
//   id_src_used  operand k is actually read
//   id_rd        destination register of the ID instruction
//   id_wr        ID instruction writes id_rd
//   id_load      ID instruction is a load (data ready after MEM)
//   ex_br_taken  branch currently in EX is taken
//   stall_if     hold the PC
//   stall_id     hold the IF/ID register
//   flush_id     kill the IF/ID contents
//   pc_redirect  select the branch target for the PC
//   fwd_sel      per-operand EX mux select, 2 bits per operand:
//                00 ID/EX value, 01 EX/MEM ALU result, 10 MEM/WB value
//   stall_cnt    load-use stall cycles, saturating
//   flush_cnt    taken-branch flushes, saturating
//------------------------------------------------------------------------------
module pipe_hazard_unit #(
   parameter int AW          = 5,
   parameter int NUM_SRC     = 2,
   parameter int ZERO_REG_EN = 1,
   parameter int CNT_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   id_valid,
   input  logic [NUM_SRC*AW-1:0]  id_src,
   input  logic [NUM_SRC-1:0]     id_src_used,
   input  logic [AW-1:0]          id_rd,
   input  logic                   id_wr,
   input  logic                   id_load,
   input  logic                   ex_br_taken,
   output logic                   stall_if,
   output logic                   stall_id,
   output logic                   flush_id,
   output logic                   pc_redirect,
   output logic [NUM_SRC*2-1:0]   fwd_sel,
   output logic [CNT_W-1:0]       stall_cnt,
   output logic [CNT_W-1:0]       flush_cnt
);

   typedef struct packed {
      logic          v;
      logic [AW-1:0] rd;
      logic          wr;
      logic          ld;
   } sb_entry_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   sb_entry_t             sb_ex;
   sb_entry_t             sb_mem;
   sb_entry_t             sb_wb;
   sb_entry_t             ex_next;
   logic [NUM_SRC-1:0]    match_ex;
   logic [NUM_SRC-1:0]    match_mem;
   logic                  load_use;
   logic                  bubble;
   logic [NUM_SRC*2-1:0]  fwd_next;
   logic                  unused_wb;

   // A source operand is a hazard against a scoreboard entry only when the
   // ID instruction is real, the operand is actually read, and the entry
   // holds a live writer of that same register. Register 0 is hardwired in
   // the regfile when ZERO_REG_EN is set, so it never needs forwarding.
   function automatic logic src_hits(input sb_entry_t e,
                                     input logic [AW-1:0] src,
                                     input logic used,
                                     input logic valid);
      logic zero_blocked;
      zero_blocked = (ZERO_REG_EN != 0) && (src == '0);
      return valid & used & e.v & e.wr & (e.rd == src) & ~zero_blocked;
   endfunction

   // Match every operand against the EX and MEM producers. WB is not
   // matched: the regfile write-through already delivers that value to ID.
   always_comb begin
      match_ex  = '0;
      match_mem = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         match_ex[k]  = src_hits(sb_ex,  id_src[k*AW +: AW], id_src_used[k], id_valid);
         match_mem[k] = src_hits(sb_mem, id_src[k*AW +: AW], id_src_used[k], id_valid);
      end
   end

   // Stall/flush decisions. A load in EX cannot forward its data in time,
   // so any consumer right behind it must wait one cycle. A taken branch
   // wins over such a stall because the stalled instruction is on the wrong
   // path and is about to be killed anyway. Whenever ID is empty, stalled
   // or flushed, EX receives a bubble instead of the ID instruction.
   always_comb begin
      load_use    = (|match_ex) & sb_ex.ld;
      stall_if    = load_use & ~ex_br_taken;
      stall_id    = load_use & ~ex_br_taken;
      flush_id    = ex_br_taken;
      pc_redirect = ex_br_taken;
      bubble      = ~id_valid | load_use | ex_br_taken;
   end

   // Next EX entry and the forwarding select that travels with it. The EX
   // producer is the youngest, so it has priority over MEM. After a
   // load-use stall the load has moved on to MEM, so the re-evaluated
   // consumer naturally picks the MEM/WB path. Bubbles carry no selects.
   always_comb begin
      ex_next  = '0;
      fwd_next = '0;
      if (!bubble) begin
         ex_next = '{v: 1'b1, rd: id_rd, wr: id_wr, ld: id_load};
         for (int k = 0; k < NUM_SRC; k++) begin
            if (match_ex[k]) begin
               fwd_next[k*2 +: 2] = 2'b01;
            end else if (match_mem[k]) begin
               fwd_next[k*2 +: 2] = 2'b10;
            end
         end
      end
   end

   // Scoreboard shift and registered forwarding select. Entries simply
   // march EX -> MEM -> WB each cycle; reset empties the whole pipeline
   // view so nothing matches until real instructions arrive again.
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_ex   <= '0;
         sb_mem  <= '0;
         sb_wb   <= '0;
         fwd_sel <= '0;
      end else begin
         sb_wb   <= sb_mem;
         sb_mem  <= sb_ex;
         sb_ex   <= ex_next;
         fwd_sel <= fwd_next;
      end
   end

   // Event counters. They stop at all-ones rather than wrapping, so a
   // long-running profile never reports a misleadingly small number.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_if && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
         if (ex_br_taken && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end

   // The WB entry retires here. It is kept so the scoreboard mirrors the
   // whole back end of the pipeline, but no decision depends on it.
   assign unused_wb = ^sb_wb;

endmodule

// File: tb/tb_pipe_hazard_unit.sv
//------------------------------------------------------------------------------
// tb_pipe_hazard_unit
//
// Drives two hazard-unit instances with identical stimulus:
//   u_dut0: default parameters (ZERO_REG_EN=1, CNT_W=16)
//   u_dut1: ZERO_REG_EN=0, CNT_W=2
// A behavioural model keeps, per instance, the last three issue slots
// (youngest first) and derives stalls, flushes, selects and counters from
// the hazard rules directly.
//------------------------------------------------------------------------------
module tb_pipe_hazard_unit;

   localparam int AW = 5;
   localparam int NS = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic                id_valid;
   logic [NS*AW-1:0]    id_src;
   logic [NS-1:0]       id_src_used;
   logic [AW-1:0]       id_rd;
   logic                id_wr;
   logic                id_load;
   logic                ex_br_taken;

   logic                obs_si  [2];
   logic                obs_sid [2];
   logic                obs_fl  [2];
   logic                obs_pr  [2];
   logic [3:0]          fwd0;
   logic [3:0]          fwd1;
   logic [15:0]         scnt0;
   logic [15:0]         fcnt0;
   logic [1:0]          scnt1;
   logic [1:0]          fcnt1;
   logic [31:0]         obs_fwd [2];
   logic [31:0]         obs_sc  [2];
   logic [31:0]         obs_fc  [2];

   int errors = 0;
   int checks = 0;

   // Model: one issue slot per cycle, index 0 is the slot now in EX.
   typedef struct {
      bit v;
      int rd;
      bit wr;
      bit ld;
   } instr_t;

   instr_t hist [2][3];
   int     m_fwd   [2];
   int     m_scnt  [2];
   int     m_fcnt  [2];
   bit     m_last_stall0;
   logic   snap_stall0;
   logic   snap_flush0;
   logic   snap_redir0;

   always #5 clk = ~clk;

   assign obs_fwd[0] = {28'd0, fwd0};
   assign obs_fwd[1] = {28'd0, fwd1};
   assign obs_sc[0]  = {16'd0, scnt0};
   assign obs_sc[1]  = {30'd0, scnt1};
   assign obs_fc[0]  = {16'd0, fcnt0};
   assign obs_fc[1]  = {30'd0, fcnt1};

   pipe_hazard_unit #(.AW(AW), .NUM_SRC(NS), .ZERO_REG_EN(1), .CNT_W(16)) u_dut0 (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .id_rd       (id_rd),
      .id_wr       (id_wr),
      .id_load     (id_load),
      .ex_br_taken (ex_br_taken),
      .stall_if    (obs_si[0]),
      .stall_id    (obs_sid[0]),
      .flush_id    (obs_fl[0]),
      .pc_redirect (obs_pr[0]),
      .fwd_sel     (fwd0),
      .stall_cnt   (scnt0),
      .flush_cnt   (fcnt0)
   );

   pipe_hazard_unit #(.AW(AW), .NUM_SRC(NS), .ZERO_REG_EN(0), .CNT_W(2)) u_dut1 (
      .clk         (clk),
      .rst         (rst),
      .id_valid    (id_valid),
      .id_src      (id_src),
      .id_src_used (id_src_used),
      .id_rd       (id_rd),
      .id_wr       (id_wr),
      .id_load     (id_load),
      .ex_br_taken (ex_br_taken),
      .stall_if    (obs_si[1]),
      .stall_id    (obs_sid[1]),
      .flush_id    (obs_fl[1]),
      .pc_redirect (obs_pr[1]),
      .fwd_sel     (fwd1),
      .stall_cnt   (scnt1),
      .flush_cnt   (fcnt1)
   );

   // Shared comparison: counts it, reports a mismatch with both values.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int cntMax(input int i);
      return (i == 0) ? 65535 : 3;
   endfunction

   // Age (0 = EX, 1 = MEM) of the youngest in-flight writer of operand k,
   // or -1 when the operand needs no forwarding.
   function automatic int producerAge(input int i, input int k);
      int src;
      src = int'(id_src[k*AW +: AW]);
      if (!id_valid || !id_src_used[k]) return -1;
      if (i == 0 && src == 0) return -1;
      for (int a = 0; a < 2; a++) begin
         if (hist[i][a].v && hist[i][a].wr && hist[i][a].rd == src) return a;
      end
      return -1;
   endfunction

   function automatic bit loadUse(input int i);
      for (int k = 0; k < NS; k++) begin
         if (producerAge(i, k) == 0 && hist[i][0].ld) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic bit expStall(input int i);
      return loadUse(i) && !ex_br_taken;
   endfunction

   // One cycle: drive at the falling edge, compare mid-cycle, then advance
   // the model on the rising edge with the same inputs.
   task automatic applyStimulus(input bit r, input bit v, input int s0, input int s1,
                                input bit [1:0] used, input int rd, input bit wr,
                                input bit ld, input bit br);
      bit     bub;
      int     nf;
      int     age;
      instr_t ni;
      @(negedge clk);
      rst         = r;
      id_valid    = v;
      id_src      = {AW'(s1), AW'(s0)};
      id_src_used = used;
      id_rd       = AW'(rd);
      id_wr       = wr;
      id_load     = ld;
      ex_br_taken = br;
      #2;
      for (int i = 0; i < 2; i++) begin
         checkOutput($sformatf("stall_if%0d", i),    32'(obs_si[i]),  32'(expStall(i)));
         checkOutput($sformatf("stall_id%0d", i),    32'(obs_sid[i]), 32'(expStall(i)));
         checkOutput($sformatf("flush_id%0d", i),    32'(obs_fl[i]),  32'(br));
         checkOutput($sformatf("pc_redirect%0d", i), 32'(obs_pr[i]),  32'(br));
         checkOutput($sformatf("fwd_sel%0d", i),     obs_fwd[i],      32'(m_fwd[i]));
         checkOutput($sformatf("stall_cnt%0d", i),   obs_sc[i],       32'(m_scnt[i]));
         checkOutput($sformatf("flush_cnt%0d", i),   obs_fc[i],       32'(m_fcnt[i]));
      end
      snap_stall0   = obs_si[0];
      snap_flush0   = obs_fl[0];
      snap_redir0   = obs_pr[0];
      m_last_stall0 = expStall(0);
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
         if (r) begin
            for (int a = 0; a < 3; a++) hist[i][a] = '{0, 0, 0, 0};
            m_fwd[i]  = 0;
            m_scnt[i] = 0;
            m_fcnt[i] = 0;
         end else begin
            bub = !v || loadUse(i) || br;
            nf  = 0;
            if (!bub) begin
               for (int k = 0; k < NS; k++) begin
                  age = producerAge(i, k);
                  if (age == 0) nf += 1 << (2*k);
                  else if (age == 1) nf += 2 << (2*k);
               end
            end
            if (expStall(i) && m_scnt[i] < cntMax(i)) m_scnt[i]++;
            if (br && m_fcnt[i] < cntMax(i)) m_fcnt[i]++;
            m_fwd[i]   = nf;
            ni         = bub ? '{0, 0, 0, 0} : '{1, rd, wr, ld};
            hist[i][2] = hist[i][1];
            hist[i][1] = hist[i][0];
            hist[i][0] = ni;
         end
      end
   endtask

   task automatic nop(input bit br);
      applyStimulus(0, 0, 0, 0, 2'b00, 0, 0, 0, br);
   endtask

   task automatic resetDut();
      applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bit     hold;
      bit     v, wr, ld, br, r;
      int     s0, s1, rd;
      bit [1:0] used;

      rst = 1'b1; id_valid = 0; id_src = '0; id_src_used = '0;
      id_rd = '0; id_wr = 0; id_load = 0; ex_br_taken = 0;
      for (int i = 0; i < 2; i++) begin
         for (int a = 0; a < 3; a++) hist[i][a] = '{0, 0, 0, 0};
         m_fwd[i] = 0; m_scnt[i] = 0; m_fcnt[i] = 0;
      end

      // Back-to-back dependency forwards from EX/MEM.
      resetDut();
      applyStimulus(0, 1, 1, 2, 2'b11, 3, 1, 0, 0);
      applyStimulus(0, 1, 3, 1, 2'b11, 4, 1, 0, 0);
      #1 checkOutput("plan_ex_fwd", obs_fwd[0], 32'h1);
      checkOutput("plan_ex_nostall", 32'(snap_stall0), 32'h0);

      // One gap forwards from MEM/WB, two gaps need nothing.
      resetDut();
      applyStimulus(0, 1, 1, 2, 2'b11, 3, 1, 0, 0);
      nop(0);
      applyStimulus(0, 1, 6, 3, 2'b11, 5, 1, 0, 0);
      #1 checkOutput("plan_mem_fwd", obs_fwd[0], 32'h8);
      resetDut();
      applyStimulus(0, 1, 1, 2, 2'b11, 3, 1, 0, 0);
      nop(0);
      nop(0);
      applyStimulus(0, 1, 6, 3, 2'b11, 5, 1, 0, 0);
      #1 checkOutput("plan_wb_nofwd", obs_fwd[0], 32'h0);

      // Load-use: one stall cycle, then both operands from MEM/WB.
      resetDut();
      applyStimulus(0, 1, 1, 0, 2'b01, 7, 1, 1, 0);
      applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 0);
      checkOutput("plan_lu_stall", 32'(snap_stall0), 32'h1);
      #1 checkOutput("plan_lu_cnt", obs_sc[0], 32'h1);
      applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 0);
      checkOutput("plan_lu_release", 32'(snap_stall0), 32'h0);
      #1 checkOutput("plan_lu_fwd", obs_fwd[0], 32'hA);

      // Taken branch overrides a load-use stall.
      resetDut();
      applyStimulus(0, 1, 1, 0, 2'b01, 7, 1, 1, 0);
      applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 1);
      checkOutput("plan_br_nostall", 32'(snap_stall0), 32'h0);
      checkOutput("plan_br_flush", 32'(snap_flush0), 32'h1);
      checkOutput("plan_br_redir", 32'(snap_redir0), 32'h1);
      #1 checkOutput("plan_br_fcnt", obs_fc[0], 32'h1);
      checkOutput("plan_br_scnt", obs_sc[0], 32'h0);
      checkOutput("plan_br_bubble", obs_fwd[0], 32'h0);
      nop(0);

      // Register 0 handling in both configurations.
      resetDut();
      applyStimulus(0, 1, 1, 2, 2'b11, 0, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 2'b11, 9, 1, 0, 0);
      #1 checkOutput("plan_r0_zero_en", obs_fwd[0], 32'h0);
      checkOutput("plan_r0_zero_dis", obs_fwd[1], 32'h5);

      // Counter saturation, then reset in the middle of a stall.
      resetDut();
      for (int n = 0; n < 5; n++) begin
         applyStimulus(0, 1, 1, 0, 2'b01, 7, 1, 1, 0);
         applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 0);
         applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 0);
      end
      #1 checkOutput("plan_sat_cnt2", obs_sc[1], 32'h3);
      checkOutput("plan_sat_cnt16", obs_sc[0], 32'h5);
      applyStimulus(0, 1, 1, 0, 2'b01, 7, 1, 1, 0);
      applyStimulus(1, 1, 7, 7, 2'b11, 8, 1, 0, 0);
      checkOutput("plan_rst_in_stall", 32'(snap_stall0), 32'h1);
      #1 checkOutput("plan_rst_cnt", obs_sc[1], 32'h0);
      checkOutput("plan_rst_fwd", obs_fwd[1], 32'h0);
      applyStimulus(0, 1, 7, 7, 2'b11, 8, 1, 0, 0);
      checkOutput("plan_rst_nostall", 32'(snap_stall0), 32'h0);

      // Randomized traffic over a small register set to force many hazards;
      // a stalled ID instruction is held just as the datapath would.
      hold = 0;
      v = 0; s0 = 0; s1 = 0; used = 0; rd = 0; wr = 0; ld = 0;
      for (int c = 0; c < 500; c++) begin
         if (!hold) begin
            v    = ($urandom_range(0, 7) != 0);
            s0   = $urandom_range(0, 3);
            s1   = $urandom_range(0, 3);
            used = 2'($urandom_range(0, 3));
            rd   = $urandom_range(0, 3);
            wr   = ($urandom_range(0, 3) != 0);
            ld   = ($urandom_range(0, 2) == 0);
         end
         br = ($urandom_range(0, 7) == 0);
         r  = ($urandom_range(0, 63) == 0);
         applyStimulus(r, v, s0, s1, used, rd, wr, ld, br);
         hold = m_last_stall0 && !r;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
